// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC/nPC with delayed-control-transfer rules, IF/ID reg.
// Ports: Clk, R(sync low), Stall, PCMUX_Signal, targets, Annul, IMem in/out, IF/ID out.
module if_fetch_stage (
  input  logic        Clk,
  input  logic        R,
  input  logic        Stall,
  input  logic [1:0]  PCMUX_Signal,
  input  logic [31:0] Branch_Target_Address,
  input  logic [31:0] ALU_out,
  input  logic        Annul,
  input  logic [31:0] IMem_DataIn,
  output logic [31:0] IMem_Address,
  output logic [31:0] PC_Out,
  output logic [31:0] nPC_Out,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC,
  output logic        IFID_Valid,
  output logic        Misalign_Error,
  output logic [31:0] Fetch_Count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  localparam logic [1:0] PCMUX_NORM = 2'b10;
  localparam logic [1:0] PCMUX_JMPL = 2'b11;

  logic [31:0] pc_q;
  logic [31:0] npc_q;
  logic [31:0] cnt_q;
  logic        mis_q;
  if_id_t      ifid_q;

  logic [31:0] tgt;
  logic [31:0] npc_d;
  logic        redir;
  logic        mis;
  if_id_t      ifid_d;

  always_comb begin
    tgt   = Branch_Target_Address;
    redir = 1'b1;
    unique case (1'b1)
      PCMUX_Signal == PCMUX_NORM: redir = 1'b0;
      PCMUX_Signal == PCMUX_JMPL: tgt = ALU_out;
      default: tgt = Branch_Target_Address;
    endcase
  end

  always_comb begin
    npc_d = npc_q + 32'd4;
    if (redir)
      npc_d = {tgt[31:2], 2'b00};
    mis = redir & (|tgt[1:0]);
  end

  // An annulled slot becomes a NOP bubble but keeps its PC.
  always_comb begin
    ifid_d.pc    = pc_q;
    ifid_d.valid = ~Annul;
    ifid_d.instr = Annul ? 32'h0 : IMem_DataIn;
  end

  always_ff @(posedge Clk) begin
    if (!R) begin
      pc_q   <= 32'h0;
      npc_q  <= 32'h4;
      cnt_q  <= 32'h0;
      mis_q  <= 1'b0;
      ifid_q <= '0;
    end else if (!Stall) begin
      pc_q   <= npc_q;
      npc_q  <= npc_d;
      mis_q  <= mis_q | mis;
      ifid_q <= ifid_d;
      if (!Annul)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  assign IMem_Address   = pc_q;
  assign PC_Out         = pc_q;
  assign nPC_Out        = npc_q;
  assign IFID_Instr     = ifid_q.instr;
  assign IFID_PC        = ifid_q.pc;
  assign IFID_Valid     = ifid_q.valid;
  assign Misalign_Error = mis_q;
  assign Fetch_Count    = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage.
// Reference model tracks PC/nPC by the fetch rules; monitor compares each edge.
module tb_if_fetch_stage;

  logic        Clk = 1'b0;
  logic        R = 1'b0;
  logic        Stall = 1'b0;
  logic [1:0]  PCMUX_Signal = 2'b10;
  logic [31:0] Branch_Target_Address = 32'h0;
  logic [31:0] ALU_out = 32'h0;
  logic        Annul = 1'b0;
  logic [31:0] IMem_DataIn;
  logic [31:0] IMem_Address, PC_Out, nPC_Out;
  logic [31:0] IFID_Instr, IFID_PC, Fetch_Count;
  logic        IFID_Valid, Misalign_Error;

  int n_chk = 0;
  int n_fail = 0;

  if_fetch_stage dut (
    .Clk(Clk), .R(R), .Stall(Stall), .PCMUX_Signal(PCMUX_Signal),
    .Branch_Target_Address(Branch_Target_Address), .ALU_out(ALU_out),
    .Annul(Annul), .IMem_DataIn(IMem_DataIn), .IMem_Address(IMem_Address),
    .PC_Out(PC_Out), .nPC_Out(nPC_Out), .IFID_Instr(IFID_Instr),
    .IFID_PC(IFID_PC), .IFID_Valid(IFID_Valid),
    .Misalign_Error(Misalign_Error), .Fetch_Count(Fetch_Count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h200) return 32'h0;
    return 32'hA000_0000 + (a >> 2);
  endfunction

  always_comb IMem_DataIn = mem(IMem_Address);

  typedef struct {
    logic [31:0] pc, npc, instr, ipc, cnt;
    logic v, mis;
  } exp_t;

  exp_t q[$];
  exp_t m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
    end
  endtask

  // Reference model: one clock edge given the sampled inputs.
  task automatic step(input logic r, input logic st, input logic [1:0] sel,
                      input logic [31:0] bta, input logic [31:0] alu,
                      input logic an);
    logic [31:0] t;
    if (!r) begin
      m = '{pc: 0, npc: 4, instr: 0, ipc: 0, cnt: 0, v: 0, mis: 0};
    end else if (!st) begin
      m.ipc   = m.pc;
      m.instr = an ? 32'h0 : mem(m.pc);
      m.v     = !an;
      if (!an) m.cnt = m.cnt + 1;
      m.pc = m.npc;
      if (sel == 2'b10) begin
        m.npc = m.npc + 4;
      end else begin
        t = (sel == 2'b11) ? alu : bta;
        if (t % 4 != 0) m.mis = 1'b1;
        m.npc = t - (t % 4);
      end
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic [1:0] sel,
                       input logic [31:0] bta, input logic [31:0] alu,
                       input logic an);
    @(negedge Clk);
    R = r; Stall = st; PCMUX_Signal = sel;
    Branch_Target_Address = bta; ALU_out = alu; Annul = an;
    step(r, st, sel, bta, alu, an);
    q.push_back(m);
  endtask

  always begin
    exp_t e;
    @(posedge Clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", PC_Out, e.pc);
      chk("npc", nPC_Out, e.npc);
      chk("imem_addr", IMem_Address, e.pc);
      chk("ifid_instr", IFID_Instr, e.instr);
      chk("ifid_pc", IFID_PC, e.ipc);
      chk("ifid_valid", {31'b0, IFID_Valid}, {31'b0, e.v});
      chk("misalign", {31'b0, Misalign_Error}, {31'b0, e.mis});
      chk("fetch_count", Fetch_Count, e.cnt);
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  s;
    logic [31:0] b, a;
    m = '{pc: 0, npc: 4, instr: 0, ipc: 0, cnt: 0, v: 0, mis: 0};
    // reset, free run
    drive(0, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    // branch from PC=4
    drive(0, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b01, 32'h40, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    // annul at PC=0x8 after restart
    drive(0, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 1);
    drive(1, 0, 2'b10, 0, 0, 0);
    // stall with jmpl held, then release
    repeat (3) drive(1, 1, 2'b11, 0, 32'h80, 0);
    drive(1, 0, 2'b11, 0, 32'h80, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    // annul and call together, zero word at 0x200
    drive(1, 0, 2'b00, 32'h200, 0, 1);
    drive(1, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    // misaligned jmpl, flag stays sticky
    drive(1, 0, 2'b11, 0, 32'h102, 0);
    repeat (3) drive(1, 0, 2'b10, 0, 0, 0);
    // nPC wrap
    drive(1, 0, 2'b01, 32'hFFFF_FFF8, 0, 0);
    repeat (3) drive(1, 0, 2'b10, 0, 0, 0);
    // reset mid-run while stalled
    drive(1, 0, 2'b01, 32'h40, 0, 0);
    drive(1, 0, 2'b10, 0, 0, 0);
    drive(0, 1, 2'b11, 0, 32'h103, 1);
    drive(1, 0, 2'b10, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) s = 2'b10;
      b = $urandom_range(0, 255) * 4;
      a = $urandom_range(0, 255) * 4;
      if ($urandom_range(0, 9) == 0) b = b | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) b = 32'hFFFF_FFF0;
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 4) == 0, s, b, a,
            $urandom_range(0, 5) == 0);
    end
    drive(1, 0, 2'b10, 0, 0, 0);
    repeat (3) @(posedge Clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage for the pipelined SPARC-subset core. It owns the PC/nPC pair and the delayed-control-transfer update rules, and drives the combinational instruction memory address. It captures the fetched word into the IF/ID register, which also supports annul and stall. Its outputs feed the ID stage and the control unit. It also keeps a sticky misaligned-target flag and a fetched-instruction counter.

## Interface
- No parameters. Widths are fixed: 32-bit data and addresses, 2-bit redirect select.
- Clk  in  1  clock; all state updates on the rising edge.
- R  in  1  reset, synchronous, active-low; R=0 at a rising edge resets all state.
- Stall  in  1  hazard-unit hold; holds PC, nPC, the IF/ID register and the counter.
- PCMUX_Signal  in  2  redirect select: 00 call, 01 branch taken, 10 normal, 11 jmpl.
- Branch_Target_Address  in  32  target for call and branch.
- ALU_out  in  32  jmpl target, computed in EX.
- Annul  in  1  squashes the word being fetched this cycle (annulled delay slot).
- IMem_DataIn  in  32  instruction word from the instruction memory, combinational.
- IMem_Address  out  32  equals the PC register, combinational.
- PC_Out, nPC_Out  out  32 each  current PC and nPC register values.
- IFID_Instr  out  32  latched instruction.
- IFID_PC  out  32  PC of the latched instruction.
- IFID_Valid  out  1  latched instruction is real (not a bubble or reset).
- Misalign_Error  out  1  sticky; a redirect target had [1:0]≠00.
- Fetch_Count  out  32  number of valid instructions loaded into IF/ID.

## Operation
- Reset values: PC=0x0, nPC=0x4, IFID_Instr=0, IFID_PC=0, IFID_Valid=0, Misalign_Error=0, Fetch_Count=0.
- Priority at each edge: reset, then Stall, then Annul/redirect, then normal.
- Stall=1 (R=1): every register holds. PCMUX_Signal and Annul are ignored and are not latched. The requester must keep them asserted until Stall drops.
- Normal (PCMUX_Signal=10): PC←nPC, nPC←nPC+4 (modulo 2^32, wraps 0xFFFFFFFC→0x0).
- Redirect (00/01 use Branch_Target_Address; 11 uses ALU_out): PC←nPC, nPC←{target[31:2],2'b00}. The delay slot at the old nPC is always fetched.
- Misaligned redirect target ([1:0]≠00): Misalign_Error←1 and the redirect still proceeds with the cleared bits. The flag clears only on reset.
- IF/ID load when not stalled and Annul=0: IFID_Instr←IMem_DataIn, IFID_PC←PC, IFID_Valid←1, Fetch_Count←Fetch_Count+1 (wraps).
- IF/ID load when Annul=1: IFID_Instr←0 (NOP), IFID_PC←PC, IFID_Valid←0, Fetch_Count unchanged. PC/nPC still advance per PCMUX_Signal.
- Annul and a redirect in the same cycle: both take effect.
- A 0x00000000 word fetched from memory with Annul=0 counts as valid.

## Timing
- The instruction memory is combinational. A word addressed by PC in cycle t appears on IFID_Instr after edge t, giving 1-cycle fetch latency.
- First edge with R=1 after reset: IFID_PC=0 and IFID_Valid=1.
- Redirect sampled at edge t: PC=old nPC after edge t, PC=target after edge t+1. There is exactly one delay-slot fetch.
- R=0 mid-run: reset values appear after that edge regardless of Stall, Annul or PCMUX_Signal. Fetch restarts from 0 once R=1.
- No combinational path from inputs to outputs except IMem_Address, which is driven directly from the PC register.

## Test plan
- Free run: memory words 0xA0000000 at 0x0, 0xA0000001 at 0x4 and 0xA0000002 at 0x8; release R. Over 3 edges IFID_PC=0,4,8, IFID_Instr matches each word, Fetch_Count=1,2,3, nPC_Out=8,0xC,0x10.
- Branch: at PC=0x4, nPC=0x8, hold PCMUX_Signal=01 with Branch_Target_Address=0x40 for one cycle. Next edge PC=0x8, nPC=0x40. Following edge PC=0x40, nPC=0x44, and IFID_PC then shows 0x8.
- Annul: Annul=1 for one cycle at PC=0x8. IFID_Instr=0, IFID_Valid=0, IFID_PC=0x8, Fetch_Count unchanged. The next fetch resumes at 0xC with Valid=1.
- Stall: Stall=1 for 3 cycles with PCMUX_Signal=11 and ALU_out=0x80 asserted throughout. All outputs stay frozen with no redirect. After release, the redirect applies: PC←old nPC, nPC←0x80.
- Misalign: jmpl with ALU_out=0x102. nPC becomes 0x100 and Misalign_Error=1. The flag stays 1 through further fetches until R=0.
- Reset mid-run: R=0 for one edge at PC=0x40 with Stall=1. Outputs become PC=0, nPC=4, IFID_Valid=0, Fetch_Count=0, Misalign_Error=0.
